// File: rtl/unidade_controle_jogo_param_if.sv
// Player/memory-side signal bundle of the game control unit.
// "slave" is the controller's view; "master" is the environment's view.
interface unidade_controle_jogo_param_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              modo;
  logic              jogada;
  logic [DATA_W-1:0] jogada_dado;
  logic [DATA_W-1:0] dado_mem;
  logic [ADDR_W-1:0] endereco;
  logic [ADDR_W-1:0] rodada;
  logic [DATA_W-1:0] leds;
  logic              mostrando;
  logic              acertou;
  logic              errou;
  logic              timeout;
  logic              pronto;
  logic [3:0]        db_estado;

  modport slave (
    input  iniciar, modo, jogada, jogada_dado, dado_mem,
    output endereco, rodada, leds, mostrando, acertou, errou, timeout, pronto, db_estado
  );

  modport master (
    output iniciar, modo, jogada, jogada_dado, dado_mem,
    input  endereco, rodada, leds, mostrando, acertou, errou, timeout, pronto, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo_param.sv
// Moore FSM controlling a memory game: optional replay of the sequence, then
// one timed play per item, ending in win, error or timeout.
module unidade_controle_jogo_param #(
  parameter int N_ROUNDS    = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int TIMEOUT_CYC = 5000,
  parameter int SHOW_CYC    = 1000
) (
  input  logic clock,
  input  logic reset,
  unidade_controle_jogo_param_if.slave bus
);

  localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SHOW_W  = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

  localparam logic [ADDR_W-1:0]  LAST_ROUND = ADDR_W'(N_ROUNDS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYC - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIA_RODADA = 4'h2,
    MOSTRA        = 4'h3,
    MOSTRA_PROX   = 4'h4,
    ESPERA        = 4'h5,
    REGISTRA      = 4'h6,
    COMPARA       = 4'h7,
    PROXIMO       = 4'h8,
    ULTIMA        = 4'h9,
    FIM_ACERTOU   = 4'hA,
    PROX_RODADA   = 4'hB,
    FIM_TIMEOUT   = 4'hC,
    FIM_MOSTRA    = 4'hD,
    FIM_ERROU     = 4'hE
  } estado_t;

  estado_t             estado;
  estado_t             proxEstado;
  logic [ADDR_W-1:0]   endereco;
  logic [ADDR_W-1:0]   rodada;
  logic [TIMER_W-1:0]  timer;
  logic [SHOW_W-1:0]   showCnt;
  logic [DATA_W-1:0]   jogadaReg;
  logic                modoReg;

  logic clrEndereco;
  logic incEndereco;
  logic clrRodada;
  logic incRodada;

  always_comb begin
    proxEstado = estado;
    case (estado)
      INICIAL:       if (bus.iniciar) proxEstado = PREPARA;
      PREPARA:       proxEstado = INICIA_RODADA;
      INICIA_RODADA: proxEstado = modoReg ? MOSTRA : ESPERA;
      MOSTRA:        if (showCnt == SHOW_LAST) proxEstado = MOSTRA_PROX;
      MOSTRA_PROX:   proxEstado = (endereco == rodada) ? FIM_MOSTRA : MOSTRA;
      FIM_MOSTRA:    proxEstado = ESPERA;
      ESPERA: begin
        if (bus.jogada)               proxEstado = REGISTRA;
        else if (timer == TIMER_LAST) proxEstado = FIM_TIMEOUT;
      end
      REGISTRA:      proxEstado = COMPARA;
      COMPARA: begin
        if (jogadaReg != bus.dado_mem) proxEstado = FIM_ERROU;
        else if (endereco == rodada)   proxEstado = ULTIMA;
        else                           proxEstado = PROXIMO;
      end
      PROXIMO:       proxEstado = ESPERA;
      ULTIMA:        proxEstado = (rodada == LAST_ROUND) ? FIM_ACERTOU : PROX_RODADA;
      PROX_RODADA:   proxEstado = INICIA_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
                     if (bus.iniciar) proxEstado = PREPARA;
      default:       proxEstado = INICIAL;
    endcase
  end

  // Clears act on entry as well, so the counters already read 0 while in the clearing state.
  always_comb begin
    clrEndereco = (estado == INICIAL) || (estado == PREPARA) || (estado == INICIA_RODADA) ||
                  (estado == FIM_MOSTRA) ||
                  (proxEstado == INICIAL) || (proxEstado == PREPARA) ||
                  (proxEstado == INICIA_RODADA) || (proxEstado == FIM_MOSTRA);
    incEndereco = ((estado == MOSTRA_PROX) && (endereco != rodada)) || (estado == PROXIMO);
    clrRodada   = (estado == INICIAL) || (estado == PREPARA) ||
                  (proxEstado == INICIAL) || (proxEstado == PREPARA);
    incRodada   = (estado == PROX_RODADA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= INICIAL;
      endereco  <= '0;
      rodada    <= '0;
      timer     <= '0;
      showCnt   <= '0;
      jogadaReg <= '0;
      modoReg   <= 1'b0;
    end else begin
      estado <= proxEstado;

      if (clrEndereco)      endereco <= '0;
      else if (incEndereco) endereco <= endereco + ADDR_W'(1);

      if (clrRodada)        rodada <= '0;
      else if (incRodada)   rodada <= rodada + ADDR_W'(1);

      // Counters only advance while staying in their state, so they never wrap.
      if ((proxEstado == ESPERA) && (estado != ESPERA))      timer <= '0;
      else if ((estado == ESPERA) && (proxEstado == ESPERA)) timer <= timer + TIMER_W'(1);

      if ((proxEstado == MOSTRA) && (estado != MOSTRA))      showCnt <= '0;
      else if ((estado == MOSTRA) && (proxEstado == MOSTRA)) showCnt <= showCnt + SHOW_W'(1);

      if (estado == REGISTRA) jogadaReg <= bus.jogada_dado;
      if (estado == PREPARA)  modoReg   <= bus.modo;
    end
  end

  assign bus.endereco  = endereco;
  assign bus.rodada    = rodada;
  // Code F is the only unused encoding, so the raw state already reads F when corrupted.
  assign bus.db_estado = estado;
  assign bus.leds      = (estado == MOSTRA) ? bus.dado_mem : '0;
  assign bus.mostrando = (estado == MOSTRA) || (estado == MOSTRA_PROX);
  assign bus.acertou   = (estado == FIM_ACERTOU);
  assign bus.errou     = (estado == FIM_ERROU);
  assign bus.timeout   = (estado == FIM_TIMEOUT);
  assign bus.pronto    = (estado == FIM_ACERTOU) || (estado == FIM_ERROU) ||
                         (estado == FIM_TIMEOUT);

endmodule

// File: doc/unidade_controle_jogo_param.md
UNIDADE_CONTROLE_JOGO_PARAM -- requirements
Module: unidade_controle_jogo_param

Interface
REQ-001 SHALL have parameter N_ROUNDS, default 16: number of rounds to win; 1 <= N_ROUNDS <= 2^ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 4: width of address and round counters.
REQ-003 SHALL have parameter DATA_W, default 4: width of play and memory data.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 5000: number of ESPERA cycles allowed per play; >= 2.
REQ-005 SHALL have parameter SHOW_CYC, default 1000: number of cycles each item is displayed in show mode; >= 1.
REQ-006 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port iniciar, input, 1: start request, level-sampled.
REQ-009 SHALL have port modo, input, 1: 1 = replay the sequence before each round; sampled only in PREPARA.
REQ-010 SHALL have port jogada, input, 1: one-cycle play-valid pulse, synchronous to clock.
REQ-011 SHALL have port jogada_dado, input, DATA_W: player's value, valid while jogada = 1.
REQ-012 SHALL have port dado_mem, input, DATA_W: sequence memory read data for endereco, combinational.
REQ-013 SHALL have port endereco, output, ADDR_W: sequence memory address, the address counter value.
REQ-014 SHALL have port rodada, output, ADDR_W: current round index, 0-based.
REQ-015 SHALL have port leds, output, DATA_W: equals dado_mem in MOSTRA, 0 otherwise.
REQ-016 SHALL have port mostrando, output, 1: high in MOSTRA and MOSTRA_PROX.
REQ-017 SHALL have ports acertou, errou, timeout, pronto, outputs, 1 each: end-of-game flags.
REQ-018 SHALL have port db_estado, output, 4: state code per REQ-020.

Function
REQ-019 SHALL be a Moore FSM: all outputs decode from the state register and internal registers only.
REQ-020 SHALL use these states and codes: INICIAL 0, PREPARA 1, INICIA_RODADA 2, MOSTRA 3, MOSTRA_PROX 4, ESPERA 5, REGISTRA 6, COMPARA 7, PROXIMO 8, ULTIMA 9, PROX_RODADA B, FIM_MOSTRA D, FIM_ERROU E, FIM_ACERTOU A, FIM_TIMEOUT C; any other code shows F and goes to INICIAL next cycle.
REQ-021 SHALL make these transitions: INICIAL->PREPARA if iniciar; PREPARA->INICIA_RODADA.
REQ-022 SHALL make INICIA_RODADA go to MOSTRA if the latched modo = 1, else to ESPERA.
REQ-023 SHALL make MOSTRA go to MOSTRA_PROX after exactly SHOW_CYC cycles in MOSTRA.
REQ-024 SHALL make MOSTRA_PROX go to FIM_MOSTRA if endereco = rodada; otherwise it increments endereco and returns to MOSTRA; FIM_MOSTRA->ESPERA.
REQ-025 SHALL give ESPERA this priority: jogada -> REGISTRA; else timer = TIMEOUT_CYC-1 -> FIM_TIMEOUT; else stay.
REQ-026 SHALL load jogada_dado into an internal register in REGISTRA; REGISTRA->COMPARA.
REQ-027 SHALL make COMPARA go to FIM_ERROU if the register != dado_mem; else to ULTIMA if endereco = rodada; else to PROXIMO.
REQ-028 SHALL make PROXIMO increment endereco, clear the timer, and go to ESPERA.
REQ-029 SHALL make ULTIMA go to FIM_ACERTOU if rodada = N_ROUNDS-1, else to PROX_RODADA.
REQ-030 SHALL make PROX_RODADA increment rodada and go to INICIA_RODADA.
REQ-031 SHALL make each FIM_* state go to PREPARA if iniciar, else hold.
REQ-032 SHALL clear endereco in INICIAL, PREPARA, INICIA_RODADA and FIM_MOSTRA.
REQ-033 SHALL clear rodada in INICIAL and PREPARA only.
REQ-034 SHALL clear the timer on every entry into ESPERA and increment it by 1 each ESPERA cycle.
REQ-035 SHALL clear the show counter on every entry into MOSTRA.
REQ-036 SHALL size timer and show counter to hold TIMEOUT_CYC-1 and SHOW_CYC-1; no counter wraps in legal operation.
REQ-037 SHALL ignore jogada outside ESPERA, and ignore modo changes after PREPARA.
REQ-038 SHALL make pronto = 1 in any FIM_* state; acertou, errou and timeout = 1 only in their own FIM state; all 0 elsewhere.

Reset
REQ-039 SHALL, on reset at any time including mid-game, force INICIAL immediately: counters, play register and latched modo = 0, all outputs 0, db_estado = 0.

Verification (N_ROUNDS=4, TIMEOUT_CYC=10, SHOW_CYC=3, memory 5,3,7,1)
REQ-040 SHALL cover a win: modo=0, correct plays for rounds 0..3 -> FIM_ACERTOU, acertou=pronto=1, rodada=3, db_estado=A.
REQ-041 SHALL cover an error: round 1, second play 4 (expected 3) -> FIM_ERROU, errou=1, endereco=1, db_estado=E.
REQ-042 SHALL cover timeout: no jogada in ESPERA -> FIM_TIMEOUT exactly 10 cycles after entry; a jogada in the 10th cycle -> REGISTRA instead.
REQ-043 SHALL cover show mode: modo=1, round 2 -> leds shows 5,3,7, each for 3 cycles, with mostrando=1; then endereco=0 in ESPERA.
REQ-044 SHALL cover reset mid-MOSTRA and restart: all outputs 0 immediately; iniciar from FIM_ERROU -> PREPARA with rodada cleared.
